// File: rtl/line_memory_responder.sv
// rtl/line_memory_responder.sv - fixed-latency single-outstanding 256-bit line memory responder
// Optional bus-protocol checker: define LINE_MEMORY_PROTOCOL_CHECK_EN.
module line_memory_responder #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              cs_i,
    input  logic              we_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 8;
`ifdef LINE_MEMORY_PROTOCOL_CHECK_EN
    localparam int LA_W = ADDR_W - 5;
`else
    localparam int LA_W = IDX_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LA_W-1:0]     addr_q, addr_d;
    logic                we_q, we_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   data_q, data_d;
    logic                ack_q, ack_d;
    logic                mem_we;
    logic [IDX_W-1:0]    idx;
    logic [LINE_W-1:0]   mem_q [DEPTH];
    logic                unused_ok;

    // Byte offset bits never select anything; upper bits only matter to the checker.
    assign unused_ok = &{1'b0, addr_i};
    assign idx       = addr_q[IDX_W-1:0];

    // Counter holds the edges still to wait; ack fires on the edge that sees zero,
    // which places it exactly LATENCY edges after acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cs_i) begin
                    addr_d  = addr_i[LA_W+4:5];
                    we_d    = we_i;
                    wdata_d = data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    ack_d   = 1'b1;
                    if (we_q) mem_we = 1'b1;
                    else      data_d = mem_q[idx];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= wdata_q;
    end

    assign data_o = data_q;
    assign ack_o  = ack_q;

`ifdef LINE_MEMORY_PROTOCOL_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == S_BUSY) begin
            if (!cs_i || (we_i != we_q) || (addr_i[ADDR_W-1:5] != addr_q) ||
                (we_q && (data_i != wdata_q)))
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
// tb/tb_line_memory_responder.sv - self-checking bench for line_memory_responder
module tb_line_memory_responder;

    localparam int L = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr_i = '0;
    logic [255:0] data_i = '0;
    logic         cs_i = 1'b0, we_i = 1'b0;
    logic [255:0] data_o;
    logic         ack_o, err_o;

    logic [31:0]  addr1 = '0;
    logic [255:0] data1 = '0;
    logic         cs1 = 1'b0, we1 = 1'b0;
    logic [255:0] data_o1;
    logic         ack1, err1;

    int checks = 0;
    int errors = 0;

    logic [255:0] ref_mem [512];
    int           written [$];

    always #5 clk = ~clk;

    line_memory_responder #(.LATENCY(L)) u_dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .cs_i(cs_i),
        .we_i(we_i), .data_o(data_o), .ack_o(ack_o), .err_o(err_o)
    );

    line_memory_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .addr_i(addr1), .data_i(data1), .cs_i(cs1),
        .we_i(we1), .data_o(data_o1), .ack_o(ack1), .err_o(err1)
    );

    function automatic int line_of(input logic [31:0] a);
        return int'(a[13:5]);
    endfunction

    // Issue one request with stable inputs until ack; report latency, read data and ack one cycle later.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                          output logic [255:0] rd, output int lat, output logic ack_after);
        int n;
        bit got;
        @(negedge clk);
        cs_i = 1'b1; we_i = w; addr_i = a; data_i = d;
        @(posedge clk);
        n = 0; got = 0;
        while (!got && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (ack_o) got = 1;
        end
        lat = got ? n : -1;
        rd = data_o;
        @(negedge clk);
        cs_i = 1'b0;
        @(posedge clk); #1;
        ack_after = ack_o;
        if (w) ref_mem[line_of(a)] = d;
        if (w) written.push_back(line_of(a));
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write_read;
        logic [255:0] rd; int lat; logic aa;
        do_req(1'b1, 32'h40, {8{32'h11111111}}, rd, lat, aa);
        checks++; if (lat != L) begin errors++; $display("FAIL wr_latency got=%0d exp=%0d", lat, L); end
        checks++; if (aa !== 1'b0) begin errors++; $display("FAIL wr_ack_width got=%b exp=0", aa); end
        do_req(1'b0, 32'h5C, '0, rd, lat, aa);
        checks++; if (lat != L) begin errors++; $display("FAIL rd_latency got=%0d exp=%0d", lat, L); end
        checks++; if (aa !== 1'b0) begin errors++; $display("FAIL rd_ack_width got=%b exp=0", aa); end
        checks++; if (rd !== {8{32'h11111111}}) begin errors++; $display("FAIL rd_data got=%h exp=%h", rd, {8{32'h11111111}}); end
    endtask

    task automatic test_alias;
        logic [255:0] rd; int lat; logic aa;
        do_req(1'b1, 32'h0, {32{8'hAA}}, rd, lat, aa);
        do_req(1'b1, 32'h4000, {32{8'hBB}}, rd, lat, aa);
        do_req(1'b0, 32'h0, '0, rd, lat, aa);
        checks++; if (rd !== ref_mem[0]) begin errors++; $display("FAIL alias_data got=%h exp=%h", rd, ref_mem[0]); end
        checks++; if (rd !== {32{8'hBB}}) begin errors++; $display("FAIL alias_bb got=%h exp=%h", rd, {32{8'hBB}}); end
    endtask

    task automatic test_random;
        logic [255:0] rd, d, exp; int lat; logic aa; logic [31:0] a; logic w; int ln;
        for (int i = 0; i < 24; i++) begin
            w = ($urandom_range(0, 1) == 1) || (written.size() == 0);
            if (w) ln = $urandom_range(0, 511);
            else   ln = written[$urandom_range(0, written.size() - 1)];
            a = $urandom;
            a[13:5] = ln[8:0];
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
            exp = ref_mem[ln];
            do_req(w, a, d, rd, lat, aa);
            checks++; if (lat != L) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, L); end
            checks++; if (aa !== 1'b0) begin errors++; $display("FAIL rand_ack_width[%0d] got=%b exp=0", i, aa); end
            if (!w) begin
                checks++; if (rd !== exp) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, rd, exp); end
            end
        end
`ifndef LINE_MEMORY_PROTOCOL_CHECK_EN
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_tied got=%b exp=0", err_o); end
`endif
    endtask

    task automatic test_back_to_back;
        logic [255:0] d; int n; bit got;
        d = {8{32'hC0FFEE01}};
        @(negedge clk);
        cs_i = 1'b1; we_i = 1'b1; addr_i = 32'h80; data_i = d;
        @(posedge clk);
        n = 0; got = 0;
        while (!got && n < 300) begin @(posedge clk); #1; n++; if (ack_o) got = 1; end
        checks++; if (n != L) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", n, L); end
        ref_mem[4] = d;
        @(negedge clk);
        we_i = 1'b0;
        n = 0; got = 0;
        while (!got && n < 300) begin @(posedge clk); #1; n++; if (ack_o) got = 1; end
        checks++; if (n != L + 2) begin errors++; $display("FAIL b2b_second_ack got=%0d exp=%0d", n, L + 2); end
        checks++; if (data_o !== d) begin errors++; $display("FAIL b2b_data got=%h exp=%h", data_o, d); end
        @(negedge clk);
        cs_i = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        logic [255:0] rd; int lat; logic aa; logic [255:0] old;
        do_req(1'b1, 32'h60, {8{32'h33333333}}, rd, lat, aa);
        do_req(1'b0, 32'h60, '0, rd, lat, aa);
        old = ref_mem[3];
        @(negedge clk);
        cs_i = 1'b1; we_i = 1'b1; addr_i = 32'h60; data_i = {32{8'hCC}};
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL midrst_ack got=%b exp=0", ack_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL midrst_data got=%h exp=0", data_o); end
        @(negedge clk); cs_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            checks++; if (ack_o !== 1'b0 || data_o !== '0) begin errors++; $display("FAIL postrst_idle ack=%b data=%h exp ack=0 data=0", ack_o, data_o); end
        end
        do_req(1'b0, 32'h60, '0, rd, lat, aa);
        checks++; if (rd !== old) begin errors++; $display("FAIL midrst_read got=%h exp=%h", rd, old); end
    endtask

    task automatic test_latency_one;
        logic [255:0] p;
        p = {8{32'h5A5A0101}};
        @(negedge clk); cs1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; data1 = p;
        @(posedge clk); #1;
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL l1_wr_ack_e0 got=%b exp=0", ack1); end
        @(posedge clk); #1;
        checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL l1_wr_ack_e1 got=%b exp=1", ack1); end
        @(negedge clk); cs1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL l1_wr_ack_e2 got=%b exp=0", ack1); end
        @(negedge clk); cs1 = 1'b1; we1 = 1'b0; addr1 = 32'h3F;
        @(posedge clk);
        @(posedge clk); #1;
        checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL l1_rd_ack got=%b exp=1", ack1); end
        checks++; if (data_o1 !== p) begin errors++; $display("FAIL l1_rd_data got=%h exp=%h", data_o1, p); end
        @(negedge clk); cs1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL l1_rd_ack_fall got=%b exp=0", ack1); end
    endtask

`ifdef LINE_MEMORY_PROTOCOL_CHECK_EN
    task automatic test_protocol;
        int n; bit got; logic [255:0] exp;
        exp = ref_mem[2];
        @(negedge clk); cs_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
        @(posedge clk); #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL prot_err_pre got=%b exp=0", err_o); end
        repeat (2) @(posedge clk);
        @(negedge clk); addr_i = 32'h60;
        @(posedge clk); #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL prot_err_set got=%b exp=1", err_o); end
        n = 3; got = 0;
        while (!got && n < 300) begin @(posedge clk); #1; n++; if (ack_o) got = 1; end
        checks++; if (n != L) begin errors++; $display("FAIL prot_latency got=%0d exp=%0d", n, L); end
        checks++; if (data_o !== exp) begin errors++; $display("FAIL prot_data got=%h exp=%h", data_o, exp); end
        @(negedge clk); cs_i = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL prot_err_sticky got=%b exp=1", err_o); end
    endtask
`endif

    initial begin
        test_reset;
        test_write_read;
        test_alias;
        test_random;
        test_back_to_back;
        test_latency_one;
`ifdef LINE_MEMORY_PROTOCOL_CHECK_EN
        test_protocol;
`endif
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
